// File: rtl/spoc_postproc_if.sv
// Handshake bundle between the SpoC-64 datapath/controller and the output formatter.
interface spoc_postproc_if #(
    parameter int PW = 32
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_decrypt;
    logic [15:0]   cmd_len;
    logic [PW-1:0] bdo;
    logic          bdo_valid;
    logic          bdo_ready;
    logic          auth_valid;
    logic          msg_auth;
    logic [PW-1:0] do_data;
    logic          do_valid;
    logic          do_ready;
    logic          do_last;

    modport master (
        output cmd_valid, cmd_decrypt, cmd_len, bdo, bdo_valid, auth_valid, msg_auth, do_ready,
        input  cmd_ready, bdo_ready, do_data, do_valid, do_last
    );

    modport slave (
        input  cmd_valid, cmd_decrypt, cmd_len, bdo, bdo_valid, auth_valid, msg_auth, do_ready,
        output cmd_ready, bdo_ready, do_data, do_valid, do_last
    );
endinterface

// File: rtl/spoc_postproc.sv
// SpoC-64 output formatter: frames bdo words with segment headers, masks the
// final message word and closes each frame with a status word.
module spoc_postproc #(
    parameter int PW        = 32,
    parameter int TAG_WORDS = 2
) (
    input logic             clk,
    input logic             rst,
    spoc_postproc_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_HDR_MSG, S_DATA, S_HDR_TAG, S_TAG, S_WAIT_AUTH, S_STATUS
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic          dec_r;
    logic          stat_r;
    logic          wvld_r;
    logic [15:0]   rem_r;
    logic [15:0]   rem_next_s;
    logic [1:0]    cnt_r;
    logic [PW-1:0] word_r;
    logic [PW-1:0] load_word_s;
    logic [PW-1:0] mask_s;
    logic          word_hs_s;
    logic          xfer_s;
    logic          tag_last_s;

    assign word_hs_s  = wvld_r && bus.do_ready;
    assign xfer_s     = bus.bdo_valid && bus.do_ready;
    assign tag_last_s = (cnt_r == 2'(TAG_WORDS - 1));
    assign rem_next_s = (rem_r > 16'd4) ? (rem_r - 16'd4) : 16'd0;

    // Byte mask for the final, possibly partial, message word (byte 0 is the MSB).
    always_comb begin
        mask_s = 32'hFFFF_FFFF;
        case (rem_r)
            16'd1:   mask_s = 32'hFF00_0000;
            16'd2:   mask_s = 32'hFFFF_0000;
            16'd3:   mask_s = 32'hFFFF_FF00;
            default: mask_s = 32'hFFFF_FFFF;
        endcase
    end

    // Header/status word captured into word_r on the cycle after state entry.
    always_comb begin
        load_word_s = 32'h0000_0000;
        case (state_r)
            S_HDR_MSG: load_word_s = {(dec_r ? 4'b0100 : 4'b0101), 1'b0, dec_r, 1'b1, dec_r, 8'h00, rem_r};
            S_HDR_TAG: load_word_s = 32'h8300_0008;
            S_STATUS:  load_word_s = stat_r ? 32'hE000_0000 : 32'hF000_0000;
            default:   load_word_s = 32'h0000_0000;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and handshake outputs; data/tag words pass straight through.
    always_comb begin
        state_s        = state_r;
        bus.cmd_ready  = 1'b0;
        bus.bdo_ready  = 1'b0;
        bus.do_valid   = 1'b0;
        bus.do_last    = 1'b0;
        bus.do_data    = word_r;
        case (state_r)
            S_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    state_s = S_HDR_MSG;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_HDR_MSG: begin
                bus.do_valid = wvld_r;
                if (word_hs_s) begin
                    if (rem_r != 16'd0) begin
                        state_s = S_DATA;
                    end else begin
                        state_s = dec_r ? S_WAIT_AUTH : S_HDR_TAG;
                    end
                end else begin
                    state_s = S_HDR_MSG;
                end
            end
            S_DATA: begin
                bus.do_valid  = bus.bdo_valid;
                bus.bdo_ready = bus.do_ready;
                bus.do_data   = bus.bdo & mask_s;
                if (xfer_s && (rem_next_s == 16'd0)) begin
                    state_s = dec_r ? S_WAIT_AUTH : S_HDR_TAG;
                end else begin
                    state_s = S_DATA;
                end
            end
            S_HDR_TAG: begin
                bus.do_valid = wvld_r;
                if (word_hs_s) begin
                    state_s = S_TAG;
                end else begin
                    state_s = S_HDR_TAG;
                end
            end
            S_TAG: begin
                bus.do_valid  = bus.bdo_valid;
                bus.bdo_ready = bus.do_ready;
                bus.do_data   = bus.bdo;
                if (xfer_s && tag_last_s) begin
                    state_s = S_STATUS;
                end else begin
                    state_s = S_TAG;
                end
            end
            S_WAIT_AUTH: begin
                if (bus.auth_valid) begin
                    state_s = S_STATUS;
                end else begin
                    state_s = S_WAIT_AUTH;
                end
            end
            S_STATUS: begin
                bus.do_valid = wvld_r;
                bus.do_last  = wvld_r;
                if (word_hs_s) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_STATUS;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Frame context: length countdown, tag word counter, status and header register.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_r  <= 1'b0;
            stat_r <= 1'b0;
            wvld_r <= 1'b0;
            rem_r  <= 16'd0;
            cnt_r  <= 2'd0;
            word_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        dec_r <= bus.cmd_decrypt;
                        rem_r <= bus.cmd_len;
                        cnt_r <= 2'd0;
                    end
                end
                S_HDR_MSG, S_HDR_TAG, S_STATUS: begin
                    if (!wvld_r) begin
                        wvld_r <= 1'b1;
                        word_r <= load_word_s;
                    end else if (bus.do_ready) begin
                        wvld_r <= 1'b0;
                        word_r <= 32'h0000_0000;
                    end
                end
                S_DATA: begin
                    if (xfer_s) begin
                        rem_r <= rem_next_s;
                    end
                end
                S_TAG: begin
                    if (xfer_s) begin
                        if (tag_last_s) begin
                            cnt_r  <= 2'd0;
                            stat_r <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + 2'd1;
                        end
                    end
                end
                S_WAIT_AUTH: begin
                    if (bus.auth_valid) begin
                        stat_r <= bus.msg_auth;
                    end
                end
                default: begin
                    wvld_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spoc_postproc.sv
// Directed bench for spoc_postproc: drives bdo from a queue, collects the do stream.
module tb_spoc_postproc;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spoc_postproc_if #(.PW(32)) bus ();
    spoc_postproc #(.PW(32), .TAG_WORDS(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    int          n_cmp = 0;
    int          n_bad = 0;
    int          bp_viol = 0;
    bit          stall = 1'b0;
    logic [31:0] src_q[$];
    logic [31:0] out_q[$];
    logic        last_q[$];
    logic [31:0] din[$];
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Source/sink pump: sample on the falling edge, update drives just after the rising edge.
    initial begin
        bit take;
        bus.bdo_valid = 1'b0;
        bus.bdo       = 32'h0;
        bus.do_ready  = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && bus.do_valid && bus.do_ready) begin
                out_q.push_back(bus.do_data);
                last_q.push_back(bus.do_last);
            end
            if (bus.bdo_ready && !bus.do_ready) bp_viol++;
            take = !rst && bus.bdo_valid && bus.bdo_ready;
            @(posedge clk);
            #1;
            if (take && src_q.size() > 0) void'(src_q.pop_front());
            bus.bdo_valid = (src_q.size() > 0);
            bus.bdo       = (src_q.size() > 0) ? src_q[0] : 32'h0;
            bus.do_ready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check_reset_outputs(input string name);
        check({name, ":cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        check({name, ":do_valid"},  32'(bus.do_valid),  32'd0);
        check({name, ":do_last"},   32'(bus.do_last),   32'd0);
        check({name, ":bdo_ready"}, 32'(bus.bdo_ready), 32'd0);
        check({name, ":do_data"},   bus.do_data,        32'h0);
    endtask

    task automatic run_frame(input string name, input bit dec, input logic [15:0] len,
                             input bit auth_ok, input bit stl, input int left);
        int cyc;
        int nl;
        out_q.delete();
        last_q.delete();
        bp_viol = 0;
        stall   = stl;
        src_q   = din;
        bus.auth_valid  = !dec;
        bus.msg_auth    = 1'b0;
        bus.cmd_valid   = 1'b1;
        bus.cmd_decrypt = dec;
        bus.cmd_len     = len;
        tick();
        bus.cmd_valid = 1'b0;
        if (dec) begin
            cyc = 0;
            while (src_q.size() > left && cyc < 500) begin
                tick();
                cyc++;
            end
            repeat (3) tick();
            check({name, ":held_off"}, 32'(src_q.size()), 32'(left));
            bus.auth_valid = 1'b1;
            bus.msg_auth   = auth_ok;
            tick();
            bus.auth_valid = 1'b0;
        end
        cyc = 0;
        while (out_q.size() < exp_q.size() && cyc < 2000) begin
            tick();
            cyc++;
        end
        repeat (3) tick();
        bus.auth_valid = 1'b0;
        stall = 1'b0;
        check({name, ":count"}, 32'(out_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            check($sformatf("%s:w%0d", name, i), out_q[i], exp_q[i]);
        nl = 0;
        foreach (last_q[i]) if (last_q[i]) nl++;
        check({name, ":n_last"}, 32'(nl), 32'd1);
        check({name, ":last_pos"}, (last_q.size() > 0) ? 32'(last_q[last_q.size()-1]) : 32'd0, 32'd1);
        check({name, ":bdo_left"}, 32'(src_q.size()), 32'(left));
        if (stl) check({name, ":bdo_rdy_bp"}, 32'(bp_viol), 32'd0);
        src_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_decrypt = 1'b0; bus.cmd_len = 16'd0;
        bus.auth_valid = 1'b0; bus.msg_auth = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        tick();
        rst = 1'b0;
        tick();

        din   = '{32'h11223344, 32'h55667788, 32'hAAAA0001, 32'hBBBB0002};
        exp_q = '{32'h52000005, 32'h11223344, 32'h55000000, 32'h83000008,
                  32'hAAAA0001, 32'hBBBB0002, 32'hE0000000};
        run_frame("enc5", 1'b0, 16'd5, 1'b0, 1'b0, 0);

        din   = '{32'hDEADBEEF, 32'h12345678};
        exp_q = '{32'h47000004, 32'hDEADBEEF, 32'hF0000000};
        run_frame("dec4_bad", 1'b1, 16'd4, 1'b0, 1'b0, 1);

        din   = '{32'hCAFEF00D, 32'h0BADC0DE, 32'h99999999};
        exp_q = '{32'h47000006, 32'hCAFEF00D, 32'h0BAD0000, 32'hE0000000};
        run_frame("dec6_ok", 1'b1, 16'd6, 1'b1, 1'b0, 1);

        din   = '{32'hAAAA0001, 32'hBBBB0002};
        exp_q = '{32'h52000000, 32'h83000008, 32'hAAAA0001, 32'hBBBB0002, 32'hE0000000};
        run_frame("enc0", 1'b0, 16'd0, 1'b0, 1'b0, 0);

        din.delete();
        exp_q.delete();
        exp_q.push_back(32'h52000025);
        for (int i = 0; i < 10; i++) begin
            din.push_back({8'(4*i+1), 8'(4*i+2), 8'(4*i+3), 8'(4*i+4)});
            if (i < 9) exp_q.push_back({8'(4*i+1), 8'(4*i+2), 8'(4*i+3), 8'(4*i+4)});
        end
        exp_q.push_back(32'h25000000);
        din.push_back(32'h7A6A0001);
        din.push_back(32'h7B6B0002);
        exp_q.push_back(32'h83000008);
        exp_q.push_back(32'h7A6A0001);
        exp_q.push_back(32'h7B6B0002);
        exp_q.push_back(32'hE0000000);
        run_frame("enc37", 1'b0, 16'd37, 1'b0, 1'b0, 0);
        run_frame("enc37_bp", 1'b0, 16'd37, 1'b0, 1'b1, 0);

        src_q = '{32'h01010101, 32'h02020202, 32'h03030303, 32'hEEEE0001, 32'hEEEE0002};
        bus.cmd_valid = 1'b1; bus.cmd_decrypt = 1'b0; bus.cmd_len = 16'd12;
        tick();
        bus.cmd_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midrst");
        tick();
        rst = 1'b0;
        src_q.delete();
        tick();

        din   = '{32'h10203040, 32'h50607080, 32'hC0DE0001, 32'hC0DE0002};
        exp_q = '{32'h52000008, 32'h10203040, 32'h50607080, 32'h83000008,
                  32'hC0DE0001, 32'hC0DE0002, 32'hE0000000};
        run_frame("enc8_after_rst", 1'b0, 16'd8, 1'b0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
